// File: rtl/msg_streamer.sv
// Message-transmit coprocessor: streams one of several parameter-stored byte
// strings to the UART TX register over rib, honouring backpressure and abort.
module msg_streamer #(
    parameter int NUM_MSG = 2,
    parameter int MAX_LEN = 16,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 5,
    parameter logic [NUM_MSG*MAX_LEN*8-1:0] MSG_DATA =
        (NUM_MSG*MAX_LEN*8)'(40'h4F_4C_4C_45_48),
    parameter logic [NUM_MSG*8-1:0] MSG_LEN = (NUM_MSG*8)'(16'h00_05),
    parameter logic [31:0] UART_ADDR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic              abort_i,
    input  logic              tx_ready_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        status_o,
    output logic [CNT_W-1:0]  sent_cnt_o,
    output logic              we_o,
    output logic [31:0]       waddr_o,
    output logic [31:0]       wdata_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STATUS_OK    = 2'b00;
    localparam logic [1:0] STATUS_BAD   = 2'b01;
    localparam logic [1:0] STATUS_ABORT = 2'b10;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [1:0]         status_q, status_d;

    logic [7:0]         startLen;
    logic [7:0]         curLen;
    logic [7:0]         curByte;
    logic               selBad;
    logic               lastByte;
    logic               xfer;

    // Out-of-range selects map to length 0 so they fall into the bad-select path.
    function automatic logic [7:0] lenOf(input logic [SEL_W-1:0] s);
        logic [7:0] l;
        l = '0;
        for (int m = 0; m < NUM_MSG; m++) begin
            if (int'(s) == m) l = MSG_LEN[m*8 +: 8];
        end
        return l;
    endfunction

    always_comb begin
        curByte = '0;
        for (int m = 0; m < NUM_MSG; m++) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (int'(sel_q) == m && int'(idx_q) == i)
                    curByte = MSG_DATA[(m*MAX_LEN+i)*8 +: 8];
            end
        end
    end

    assign startLen = lenOf(sel_i);
    assign curLen   = lenOf(sel_q);
    assign selBad   = (int'(sel_i) >= NUM_MSG) || (startLen == 8'd0);
    assign lastByte = ((8'(idx_q) + 8'd1) == curLen);
    assign xfer     = (state_q == SEND) && tx_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            status_q <= STATUS_OK;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            status_q <= status_d;
        end
    end

    // A transfer coinciding with abort still counts; abort status overrides ok.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sel_d = sel_i;
                    cnt_d = '0;
                    idx_d = '0;
                    if (selBad) begin
                        status_d = STATUS_BAD;
                        state_d  = DONE;
                    end else begin
                        status_d = STATUS_OK;
                        state_d  = SEND;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (lastByte) state_d = DONE;
                end
                if (abort_i) begin
                    status_d = STATUS_ABORT;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o    = (state_q == IDLE);
    assign busy_o     = (state_q == SEND) || (state_q == DONE);
    assign done_o     = (state_q == DONE);
    assign we_o       = (state_q == SEND);
    assign waddr_o    = we_o ? UART_ADDR : 32'h0;
    assign wdata_o    = we_o ? {24'h0, curByte} : 32'h0;
    assign status_o   = status_q;
    assign sent_cnt_o = cnt_q;

endmodule

// File: tb/tb_msg_streamer.sv
// Directed self-checking bench for msg_streamer: normal send, stalls, bad
// selects, abort, held start and mid-transfer reset.
module tb_msg_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        startI;
    logic [1:0]  selI;
    logic        abortI;
    logic        txReadyI;
    logic        readyO;
    logic        busyO;
    logic        doneO;
    logic [1:0]  statusO;
    logic [4:0]  sentCntO;
    logic        weO;
    logic [31:0] waddrO;
    logic [31:0] wdataO;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int startCyc    = 0;

    logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    msg_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (startI),
        .sel_i      (selI),
        .abort_i    (abortI),
        .tx_ready_i (txReadyI),
        .ready_o    (readyO),
        .busy_o     (busyO),
        .done_o     (doneO),
        .status_o   (statusO),
        .sent_cnt_o (sentCntO),
        .we_o       (weO),
        .waddr_o    (waddrO),
        .wdata_o    (wdataO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] sl,
                                 input logic a, input logic t);
        rst      = r;
        startI   = s;
        selI     = sl;
        abortI   = a;
        txReadyI = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput("ready_xor_busy", {31'b0, readyO ^ busyO}, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},  {31'b0, readyO},   32'd1);
        checkOutput({tag, "_busy"},   {31'b0, busyO},    32'd0);
        checkOutput({tag, "_done"},   {31'b0, doneO},    32'd0);
        checkOutput({tag, "_we"},     {31'b0, weO},      32'd0);
        checkOutput({tag, "_waddr"},  waddrO,            32'd0);
        checkOutput({tag, "_wdata"},  wdataO,            32'd0);
        checkOutput({tag, "_status"}, {30'b0, statusO},  32'd0);
        checkOutput({tag, "_cnt"},    {27'b0, sentCntO}, 32'd0);
    endtask

    task automatic checkDone(input string tag, input logic [31:0] st, input logic [31:0] cnt);
        checkOutput({tag, "_done"},   {31'b0, doneO},    32'd1);
        checkOutput({tag, "_busy"},   {31'b0, busyO},    32'd1);
        checkOutput({tag, "_ready"},  {31'b0, readyO},   32'd0);
        checkOutput({tag, "_we"},     {31'b0, weO},      32'd0);
        checkOutput({tag, "_status"}, {30'b0, statusO},  st);
        checkOutput({tag, "_cnt"},    {27'b0, sentCntO}, cnt);
    endtask

    // Walks the HELLO message cycle by cycle; the byte index only advances
    // on cycles the sink was ready.
    task automatic streamHello(input logic holdStart, input logic [15:0] txPat,
                               input int abortCycle);
        int k;
        k = 0;
        for (int c = 0; c < 16; c++) begin
            checkOutput("send_we",    {31'b0, weO}, 32'd1);
            checkOutput("send_waddr", waddrO,       32'h3000_0000);
            checkOutput("send_wdata", wdataO,       {24'h0, hello[k]});
            applyStimulus(1'b0, holdStart, 2'd0, (c == abortCycle), txPat[c]);
            step();
            if (txPat[c]) k++;
            if (k == 5 || c == abortCycle) break;
        end
        applyStimulus(1'b0, holdStart, 2'd0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkResetValues("reset");

        $display("[TB] basic HELLO run");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        startCyc = cyc;
        streamHello(1'b0, 16'hFFFF, -1);
        checkDone("basic", 32'd0, 32'd5);
        checkOutput("basic_latency", 32'(cyc - startCyc), 32'd5);
        step();
        checkOutput("basic_ready_back", {31'b0, readyO}, 32'd1);

        $display("[TB] stalled run");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        startCyc = cyc;
        streamHello(1'b0, 16'hFFF1, -1);
        checkDone("stall", 32'd0, 32'd5);
        checkOutput("stall_latency", 32'(cyc - startCyc), 32'd8);
        step();
        checkOutput("stall_ready_back", {31'b0, readyO}, 32'd1);

        $display("[TB] empty and out-of-range selects");
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkDone("empty", 32'd1, 32'd0);
        step();
        checkOutput("empty_ready", {31'b0, readyO}, 32'd1);
        checkOutput("empty_we",    {31'b0, weO},    32'd0);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkDone("badsel", 32'd1, 32'd0);
        step();
        checkOutput("badsel_ready", {31'b0, readyO}, 32'd1);
        checkOutput("badsel_we",    {31'b0, weO},    32'd0);

        $display("[TB] abort on third byte");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        streamHello(1'b0, 16'hFFFF, 2);
        checkDone("abort", 32'd2, 32'd3);
        step();
        checkOutput("abort_ready", {31'b0, readyO}, 32'd1);
        checkOutput("abort_status_held", {30'b0, statusO}, 32'd2);

        $display("[TB] start held high across runs");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        checkOutput("held_status_clr", {30'b0, statusO},  32'd0);
        checkOutput("held_cnt_clr",    {27'b0, sentCntO}, 32'd0);
        streamHello(1'b1, 16'hFFFF, -1);
        checkDone("held1", 32'd0, 32'd5);
        step();
        checkOutput("held_idle", {31'b0, readyO}, 32'd1);
        checkOutput("held_idle_we", {31'b0, weO}, 32'd0);
        step();
        checkOutput("held_restart_cnt", {27'b0, sentCntO}, 32'd0);
        streamHello(1'b0, 16'hFFFF, -1);
        checkDone("held2", 32'd0, 32'd5);
        step();

        $display("[TB] reset in the middle of a transfer");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkOutput("mid_wdata0", wdataO, 32'h48);
        step();
        checkOutput("mid_wdata1", wdataO, 32'h45);
        step();
        checkOutput("mid_cnt2", {27'b0, sentCntO}, 32'd2);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkResetValues("midrst");
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        step();
        streamHello(1'b0, 16'hFFFF, -1);
        checkDone("after_rst", 32'd0, 32'd5);
        step();
        checkOutput("final_ready", {31'b0, readyO}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/msg_streamer.md
Name: msg_streamer

Overview:
- Multi-cycle message-transmit coprocessor, invoked by ex when it decodes a message-send instruction.
- Streams one of NUM_MSG constant byte strings, stored in parameters, to the UART write address through rib, one byte per accepted write.
- Honours sink backpressure, supports abort, and reports completion status and the number of bytes sent back to ex.

Parameters:
NUM_MSG, 2, number of stored messages
MAX_LEN, 16, maximum bytes per message
SEL_W, 2, width of message select; must satisfy 2^SEL_W >= NUM_MSG
CNT_W, 5, byte counter width; must satisfy 2^CNT_W > MAX_LEN
MSG_DATA, msg0 = ASCII "HELLO", rest zero, packed NUM_MSG*MAX_LEN*8 bits; byte i of msg m at [(m*MAX_LEN+i)*8 +: 8]
MSG_LEN, msg0 = 5, msg1 = 0, packed NUM_MSG*8 bits; length of msg m at [m*8 +: 8], valid range 0..MAX_LEN
UART_ADDR, 32'h3000_0000, rib write address of the UART TX register

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start_i  in  1  request from ex; sampled only in IDLE
sel_i  in  SEL_W  message index; sampled together with start_i
abort_i  in  1  terminates an active transfer
tx_ready_i  in  1  sink accepts the current write this cycle
ready_o  out  1  high in IDLE (block accepts start)
busy_o  out  1  high in SEND and DONE
done_o  out  1  one-cycle pulse in DONE
status_o  out  2  00 ok, 01 bad select/empty, 10 aborted; held until next accepted start
sent_cnt_o  out  CNT_W  bytes accepted in the last run; held until next accepted start
we_o  out  1  write request to rib
waddr_o  out  32  UART_ADDR while we_o, else 0
wdata_o  out  32  {24'h0, byte} while we_o, else 0

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, ready_o=1, busy_o=0, done_o=0, we_o=0, waddr_o=0, wdata_o=0, status_o=00, sent_cnt_o=0, internal index=0.
- Reset applies in any state, including mid-SEND. No further writes are issued after a reset.
- FSM states: IDLE, SEND, DONE.
- IDLE, start_i=1:
  - Latch sel_i and clear sent_cnt_o.
  - If sel_i >= NUM_MSG, or the selected length is 0: go to DONE with status 01; no write is issued.
  - Otherwise: go to SEND with index=0 and status 00.
- IDLE, start_i=0: remain in IDLE.
- SEND:
  - Drive we_o=1, waddr_o=UART_ADDR, wdata_o={24'h0, MSG_DATA byte[sel][index]}.
  - A transfer occurs when we_o=1 and tx_ready_i=1 in the same cycle. On a transfer: index and sent_cnt_o each increment.
  - Last byte: a transfer at index = len-1 moves the FSM to DONE.
  - Stall: if tx_ready_i=0, the outputs remain stable and the index is not advanced. There is no timeout.
- Abort:
  - abort_i=1 in SEND moves the FSM to DONE with status 10.
  - A transfer in the same cycle as the abort still counts in sent_cnt_o.
  - If the abort coincides with the last-byte transfer, status becomes 10 and sent_cnt_o=len.
  - abort_i has no effect in IDLE or DONE.
- DONE: lasts one cycle. done_o=1, busy_o=1, ready_o=0, we_o=0; then return to IDLE.
- start_i is ignored in SEND and DONE; no queuing.
- Latency: start accepted at cycle N gives the first we_o at N+1. With tx_ready_i held at 1, the last byte is written at N+len, done_o pulses at N+len+1, and ready_o is back at N+len+2.
- ready_o and busy_o are mutually exclusive; exactly one is high in every cycle.
- All registered outputs change only at clk edges. we_o, waddr_o and wdata_o are decoded from state and index only, not combinationally from tx_ready_i.

Test Plan:
- Reset, then start_i=1 with sel_i=0 and tx_ready_i=1 constant -> we_o high 5 consecutive cycles with wdata 0x48, 0x45, 0x4C, 0x4C, 0x4F and waddr 0x3000_0000; done_o pulses the next cycle; status 00; sent_cnt 5; ready_o high 7 cycles after start.
- Same run with tx_ready_i=0 during the 2nd through 4th SEND cycles -> wdata held at 0x45 for those 3 cycles; no byte skipped or repeated; done_o arrives 3 cycles later than in the first scenario.
- start_i with sel_i=1 (length 0), and separately with sel_i=3 (>= NUM_MSG) -> we_o never asserted; done_o the cycle after start; status 01; sent_cnt 0.
- abort_i asserted in the cycle of the 3rd accepted byte (0x4C) -> sent_cnt 3, status 10, we_o low next cycle, done_o pulse, then IDLE.
- start_i held high through a whole run -> second run begins only from IDLE after DONE; no writes in the DONE cycle; status/sent_cnt cleared at the new start.
- rst pulsed during SEND after 2 bytes -> following cycle all outputs at reset values (ready_o=1, we_o=0, sent_cnt 0, status 00); a fresh start then sends the full message from 0x48.
